// File: rtl/noc_pkg.sv
// Shared types and width helpers for the NoC output-port scheduler.
package noc_pkg;

  typedef enum logic [1:0] {
    QOS_LOW    = 2'd0,
    QOS_NORMAL = 2'd1,
    QOS_HIGH   = 2'd2,
    QOS_URGENT = 2'd3
  } qos_level_t;

  localparam int NUM_QOS = 4;
  localparam int STAT_W  = 32;

  typedef logic [STAT_W-1:0] sched_stat_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cred_width(input int max_cred);
    return $clog2(max_cred + 1);
  endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping, as a one-hot winner.
module noc_rr_picker
  import noc_pkg::*;
#(
  parameter int N = 5,
  localparam int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/noc_port_scheduler.sv
// NoC output-port scheduler: wormhole lock, per-VC credits, WRR across QoS classes, RR within a class.
// Optional starvation aging enabled by defining NOC_SCHED_AGING_EN.
module noc_port_scheduler
  import noc_pkg::*;
#(
  parameter int NUM_REQ     = 5,
  parameter int NUM_VC      = 4,
  parameter int MAX_CREDITS = 8,
  parameter int WEIGHT_W    = 4,
  parameter int AGE_W       = 8,
  localparam int VC_W       = idx_width(NUM_VC),
  localparam int CRED_W     = cred_width(MAX_CREDITS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][1:0]             req_qos,
  input  logic [NUM_REQ-1:0]                  req_head,
  input  logic [NUM_REQ-1:0]                  req_tail,
  input  logic [NUM_REQ-1:0][VC_W-1:0]        req_vc,
  input  logic                                out_ready,
  input  logic [NUM_VC-1:0]                   credit_return,
  input  logic [NUM_QOS-1:0][WEIGHT_W-1:0]    cfg_weight,
  input  logic [AGE_W-1:0]                    cfg_age_threshold,
  output logic [NUM_REQ-1:0]                  grant,
  output logic                                out_valid,
  output logic [VC_W-1:0]                     out_vc,
  output logic [NUM_VC-1:0][CRED_W-1:0]       credit_count,
  output logic                                locked,
  output logic [NUM_REQ-1:0]                  starved,
  output sched_stat_t [NUM_QOS-1:0]           stat_grants
);

  localparam int PTR_W = idx_width(NUM_REQ);

  logic [NUM_VC-1:0][CRED_W-1:0]      credit_q;
  logic                               locked_q;
  logic [PTR_W-1:0]                   owner_q;
  logic [NUM_QOS-1:0][WEIGHT_W-1:0]   used_q;
  logic [NUM_QOS-1:0][PTR_W-1:0]      ptr_q;
  sched_stat_t [NUM_QOS-1:0]          stat_q;

  logic [NUM_REQ-1:0]                 elig;
  logic [NUM_REQ-1:0]                 cand;
  logic [NUM_QOS-1:0][NUM_REQ-1:0]    cls_req;
  logic [NUM_QOS-1:0][NUM_REQ-1:0]    cls_gnt;
  logic [NUM_QOS-1:0][PTR_W-1:0]      cls_idx;
  logic [NUM_QOS-1:0]                 cls_any;
  logic [NUM_QOS-1:0]                 has_tok;
  logic [NUM_QOS-1:0][WEIGHT_W-1:0]   eff_w;
  logic                               sel_valid;
  logic                               reload;
  logic [1:0]                         sel_cls;
  logic                               wrr_grant;
  logic [PTR_W-1:0]                   win_idx;
  logic [NUM_VC-1:0]                  vc_dec;
  logic                               age_hit;
  logic [PTR_W-1:0]                   age_idx;
  logic [NUM_REQ-1:0]                 starved_w;

  function automatic logic [CRED_W-1:0] sat_inc_credit(input logic [CRED_W-1:0] c);
    return (c >= CRED_W'(MAX_CREDITS)) ? CRED_W'(MAX_CREDITS) : c + CRED_W'(1);
  endfunction

  always_comb begin
    elig    = '0;
    cand    = '0;
    cls_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (credit_q[req_vc[i]] != '0) && out_ready;
      cand[i] = elig[i] && req_head[i];
      for (int c = 0; c < NUM_QOS; c++)
        cls_req[c][i] = cand[i] && (req_qos[i] == 2'(c));
    end
  end

  for (genvar c = 0; c < NUM_QOS; c++) begin : g_pick
    noc_rr_picker #(.N(NUM_REQ)) u_pick (
      .req (cls_req[c]),
      .ptr (ptr_q[c]),
      .gnt (cls_gnt[c]),
      .idx (cls_idx[c]),
      .any (cls_any[c])
    );
  end

  // A zero weight still grants one packet per round so no class is silenced by config.
  always_comb begin
    eff_w   = '0;
    has_tok = '0;
    for (int c = 0; c < NUM_QOS; c++) begin
      eff_w[c]   = (cfg_weight[c] == '0) ? WEIGHT_W'(1) : cfg_weight[c];
      has_tok[c] = used_q[c] < eff_w[c];
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_cls   = 2'd0;
    reload    = 1'b0;
    for (int c = 0; c < NUM_QOS; c++) begin
      if (cls_any[c] && has_tok[c]) begin
        sel_valid = 1'b1;
        sel_cls   = 2'(c);
      end
    end
    if (!sel_valid && (|cand)) begin
      reload = 1'b1;
      for (int c = 0; c < NUM_QOS; c++) begin
        if (cls_any[c]) begin
          sel_valid = 1'b1;
          sel_cls   = 2'(c);
        end
      end
    end
  end

`ifdef NOC_SCHED_AGING_EN
  logic [NUM_REQ-1:0][AGE_W-1:0] wait_q;

  function automatic logic [AGE_W-1:0] sat_inc_age(input logic [AGE_W-1:0] a);
    return (a == '1) ? a : a + AGE_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i])
          wait_q[i] <= '0;
        else if (req_valid[i])
          wait_q[i] <= sat_inc_age(wait_q[i]);
      end
    end
  end

  always_comb begin
    starved_w = '0;
    age_hit   = 1'b0;
    age_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      starved_w[i] = wait_q[i] >= cfg_age_threshold;
      if (starved_w[i] && cand[i]) begin
        age_hit = 1'b1;
        age_idx = PTR_W'(i);
      end
    end
  end
`else
  logic unused_age;
  assign unused_age = ^cfg_age_threshold;
  assign starved_w  = '0;
  assign age_hit    = 1'b0;
  assign age_idx    = '0;
`endif

  // Priority: packet owner while locked, then starved heads, then WRR class winner.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    wrr_grant = 1'b0;
    if (locked_q) begin
      if (elig[owner_q] && !req_head[owner_q]) begin
        grant[owner_q] = 1'b1;
        win_idx        = owner_q;
      end
    end else if (age_hit) begin
      grant[age_idx] = 1'b1;
      win_idx        = age_idx;
    end else if (sel_valid) begin
      grant     = cls_gnt[sel_cls];
      win_idx   = cls_idx[sel_cls];
      wrr_grant = 1'b1;
    end
  end

  assign out_valid = |grant;
  assign out_vc    = out_valid ? req_vc[win_idx] : '0;

  always_comb begin
    vc_dec = '0;
    for (int v = 0; v < NUM_VC; v++)
      vc_dec[v] = out_valid && (out_vc == VC_W'(v));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++)
        credit_q[v] <= CRED_W'(MAX_CREDITS);
      locked_q <= 1'b0;
      owner_q  <= '0;
      used_q   <= '0;
      ptr_q    <= '0;
      stat_q   <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (credit_return[v] && !vc_dec[v])
          credit_q[v] <= sat_inc_credit(credit_q[v]);
        else if (vc_dec[v] && !credit_return[v])
          credit_q[v] <= credit_q[v] - CRED_W'(1);
      end
      if (out_valid) begin
        if (req_head[win_idx] && !req_tail[win_idx]) begin
          locked_q <= 1'b1;
          owner_q  <= win_idx;
        end else if (locked_q && req_tail[win_idx]) begin
          locked_q <= 1'b0;
        end
        if (req_head[win_idx])
          stat_q[req_qos[win_idx]] <= stat_q[req_qos[win_idx]] + 32'd1;
      end
      if (wrr_grant) begin
        ptr_q[sel_cls] <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        for (int c = 0; c < NUM_QOS; c++) begin
          if (reload)
            used_q[c] <= (2'(c) == sel_cls) ? WEIGHT_W'(1) : '0;
          else if (2'(c) == sel_cls)
            used_q[c] <= used_q[c] + WEIGHT_W'(1);
        end
      end
    end
  end

  assign credit_count = credit_q;
  assign locked       = locked_q;
  assign starved      = starved_w;
  assign stat_grants  = stat_q;

endmodule

// File: tb/tb_noc_port_scheduler.sv
// Directed bench for noc_port_scheduler: vector table plus hand-written multi-cycle sequences.
module tb_noc_port_scheduler;
  import noc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        req_valid;
  logic [4:0][1:0]   req_qos;
  logic [4:0]        req_head;
  logic [4:0]        req_tail;
  logic [4:0][1:0]   req_vc;
  logic              out_ready;
  logic [3:0]        credit_return;
  logic [3:0][3:0]   cfg_weight;
  logic [7:0]        cfg_age_threshold;
  logic [4:0]        grant;
  logic              out_valid;
  logic [1:0]        out_vc;
  logic [3:0][3:0]   credit_count;
  logic              locked;
  logic [4:0]        starved;
  sched_stat_t [3:0] stat_grants;

  int n_checks = 0;
  int n_fail   = 0;

  noc_port_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_qos           (req_qos),
    .req_head          (req_head),
    .req_tail          (req_tail),
    .req_vc            (req_vc),
    .out_ready         (out_ready),
    .credit_return     (credit_return),
    .cfg_weight        (cfg_weight),
    .cfg_age_threshold (cfg_age_threshold),
    .grant             (grant),
    .out_valid         (out_valid),
    .out_vc            (out_vc),
    .credit_count      (credit_count),
    .locked            (locked),
    .starved           (starved),
    .stat_grants       (stat_grants)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0] valid;
    logic [4:0] head;
    logic [4:0] tail;
    logic [9:0] qos;
    logic [9:0] vc;
    logic       ordy;
    logic [3:0] cret;
    logic [4:0] exp_grant;
    logic [1:0] exp_vc;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic [4:0] v, h, t, input logic [9:0] q, c,
                              input logic o, input logic [3:0] cr,
                              input logic [4:0] eg, input logic [1:0] ev);
    vec_t r;
    r.valid = v; r.head = h; r.tail = t; r.qos = q; r.vc = c;
    r.ordy = o; r.cret = cr; r.exp_grant = eg; r.exp_vc = ev;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, h, t, input logic [9:0] q, c,
                       input logic o, input logic [3:0] cr);
    req_valid = v; req_head = h; req_tail = t; req_qos = q; req_vc = c;
    out_ready = o; credit_return = cr;
  endtask

  task automatic idle();
    drive(5'b0, 5'b0, 5'b0, 10'b0, 10'b0, 1'b1, 4'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [9:0] Q4 = 10'b00_11_10_01_00;
  localparam logic [9:0] QN = 10'b01_01_01_01_01;

  initial begin
    logic [4:0] wrr_g [8];
    logic [1:0] wrr_v [8];
    wrr_g = '{5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00100, 5'b00100, 5'b00010, 5'b00001};
    wrr_v = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0};

    tbl[0] = mk(5'b00001, 5'b00000, 5'b00000, Q4, Q4, 1'b1, 4'hF, 5'b0, 2'd0);
    tbl[1] = mk(5'b01111, 5'b01111, 5'b01111, Q4, Q4, 1'b0, 4'hF, 5'b0, 2'd0);
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 8; j++)
        tbl[2 + r*8 + j] = mk(5'b01111, 5'b01111, 5'b01111, Q4, Q4, 1'b1, 4'hF,
                              wrr_g[j], wrr_v[j]);

    rst_n = 1'b0;
    idle();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    cfg_age_threshold = 8'd255;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, and credit saturation on a return at full credits
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vc", 64'(out_vc), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_starved", 64'(starved), 64'd0);
    for (int v = 0; v < 4; v++)
      chk($sformatf("rst_credit%0d", v), 64'(credit_count[v]), 64'd8);
    for (int c = 0; c < 4; c++)
      chk($sformatf("rst_stat%0d", c), 64'(stat_grants[c]), 64'd0);
    credit_return = 4'b0001;
    next_cycle();
    credit_return = 4'b0000;
    @(negedge clk);
    chk("credit_saturate", 64'(credit_count[0]), 64'd8);

    // WRR table: weights LOW1 NORMAL1 HIGH2 URGENT4
    do_reset();
    cfg_weight[0] = 4'd1; cfg_weight[1] = 4'd1; cfg_weight[2] = 4'd2; cfg_weight[3] = 4'd4;
    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].valid, tbl[k].head, tbl[k].tail, tbl[k].qos, tbl[k].vc,
            tbl[k].ordy, tbl[k].cret);
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", k), 64'(grant), 64'(tbl[k].exp_grant));
      chk($sformatf("tbl%0d_out_vc", k), 64'(out_vc), 64'(tbl[k].exp_vc));
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("wrr_stat_low", 64'(stat_grants[0]), 64'd2);
    chk("wrr_stat_normal", 64'(stat_grants[1]), 64'd2);
    chk("wrr_stat_high", 64'(stat_grants[2]), 64'd4);
    chk("wrr_stat_urgent", 64'(stat_grants[3]), 64'd8);
    chk("wrr_credit3", 64'(credit_count[3]), 64'd8);

    // Wormhole: req0 3-flit on VC1 beats req1 single-flit, req1 follows on cycle 4
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    drive(5'b00011, 5'b00011, 5'b00010, 10'b0, 10'b00_00_00_11_01, 1'b1, 4'b0);
    @(negedge clk);
    chk("wh_head_grant", 64'(grant), 64'b00001);
    chk("wh_head_vc", 64'(out_vc), 64'd1);
    next_cycle();
    req_head[0] = 1'b0;
    @(negedge clk);
    chk("wh_body_grant", 64'(grant), 64'b00001);
    chk("wh_body_locked", 64'(locked), 64'd1);
    next_cycle();
    req_tail[0] = 1'b1;
    @(negedge clk);
    chk("wh_tail_grant", 64'(grant), 64'b00001);
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wh_req1_grant", 64'(grant), 64'b00010);
    chk("wh_req1_vc", 64'(out_vc), 64'd3);
    chk("wh_unlocked", 64'(locked), 64'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("wh_credit1", 64'(credit_count[1]), 64'd5);
    chk("wh_credit3", 64'(credit_count[3]), 64'd7);
    chk("wh_stat_low", 64'(stat_grants[0]), 64'd2);

    // Reset in the middle of a packet drops the lock and refills credits
    do_reset();
    drive(5'b00001, 5'b00001, 5'b00000, 10'b0, 10'b0, 1'b1, 4'b0);
    next_cycle();
    req_head[0] = 1'b0;
    @(negedge clk);
    chk("mid_locked", 64'(locked), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", 64'(locked), 64'd0);
    chk("mid_rst_credit0", 64'(credit_count[0]), 64'd8);
    rst_n = 1'b1;
    #1;
    chk("mid_body_ignored", 64'(grant), 64'd0);

    // Credit drain on VC2 and recovery from a single return
    do_reset();
    drive(5'b00001, 5'b00001, 5'b00001, 10'b0, 10'b00_00_00_00_10, 1'b1, 4'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_grant", k), 64'(grant), 64'b00001);
      next_cycle();
    end
    @(negedge clk);
    chk("drain_held", 64'(grant), 64'd0);
    chk("drain_credit2", 64'(credit_count[2]), 64'd0);
    credit_return = 4'b0100;
    next_cycle();
    credit_return = 4'b0000;
    @(negedge clk);
    chk("drain_credit_back", 64'(credit_count[2]), 64'd1);
    chk("drain_regrant", 64'(grant), 64'b00001);
    next_cycle();
    idle();

    // Strict rotation among four NORMAL requesters; zero weight behaves as one
    do_reset();
    cfg_weight = '0;
    drive(5'b01111, 5'b01111, 5'b01111, QN, 10'b0, 1'b1, 4'hF);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_grant", k), 64'(grant), 64'(5'b00001 << (k % 4)));
      next_cycle();
    end
    idle();

    // URGENT weight 15 against a LOW requester
    do_reset();
    cfg_weight[0] = 4'd1; cfg_weight[1] = 4'd1; cfg_weight[2] = 4'd1; cfg_weight[3] = 4'd15;
    cfg_age_threshold = 8'd5;
    drive(5'b00011, 5'b00011, 5'b00011, 10'b00_00_00_11_00, 10'b00_00_00_01_00, 1'b1, 4'hF);
`ifdef NOC_SCHED_AGING_EN
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("age%0d_grant", k), 64'(grant), 64'b00010);
      chk($sformatf("age%0d_starved0", k), 64'(starved[0]), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("age_starved0", 64'(starved[0]), 64'd1);
    chk("age_promoted_grant", 64'(grant), 64'b00001);
    next_cycle();
    @(negedge clk);
    chk("age_cleared", 64'(starved[0]), 64'd0);
    chk("age_back_to_urgent", 64'(grant), 64'b00010);
`else
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk($sformatf("wrr15_%0d_grant", k), 64'(grant), 64'b00010);
      chk($sformatf("wrr15_%0d_starved", k), 64'(starved), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("wrr15_low_grant", 64'(grant), 64'b00001);
`endif
    next_cycle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
